// File: rtl/packet_gen.sv
// ---------------------------------------------------------------------------
// packet_gen
//
// Streaming packet generator. A single-cycle start strobe latches the packet
// configuration. The block then emits packet_count packets of packet_len
// bytes each on a 512-bit AXI4-Stream master. Every packet carries
// incrementing 16-bit words. Consecutive packets are separated by
// idle_cycles cycles with tvalid low.
//
// Ports
//   clk             in   1    clock
//   resetn          in   1    synchronous, active-low reset
//   packet_len      in   16   packet length in bytes (1..9600)
//   packet_count    in   32   packets per run
//   idle_cycles     in   16   tvalid-low cycles between packets
//   initial_value   in   16   first data word of the first packet
//   start           in   1    single-cycle run strobe (honoured only in IDLE)
//   busy            out  1    high while a run is in progress
//   axis_out_tdata  out  512  lane i occupies bits [16i+15:16i]
//   axis_out_tkeep  out  64   byte enables
//   axis_out_tlast  out  1    last beat of a packet
//   axis_out_tvalid out  1    stream valid
//   axis_out_tready in   1    stream ready
// ---------------------------------------------------------------------------
module packet_gen (
    input  logic         clk,
    input  logic         resetn,
    input  logic [15:0]  packet_len,
    input  logic [31:0]  packet_count,
    input  logic [15:0]  idle_cycles,
    input  logic [15:0]  initial_value,
    input  logic         start,
    output logic         busy,
    output logic [511:0] axis_out_tdata,
    output logic [63:0]  axis_out_tkeep,
    output logic         axis_out_tlast,
    output logic         axis_out_tvalid,
    input  logic         axis_out_tready
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    // Field order matches the {tdata, tkeep, tlast} concatenation, so a
    // whole beat can be loaded into the output registers in one assignment.
    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] idle_q;
    logic [15:0] pkt_first;
    logic [15:0] gap_cnt;
    logic [31:0] packets_remaining;
    logic [7:0]  beat;

    beat_t start_beat;   // beat 0 of a new run, built from the live config
    beat_t next_beat;    // next beat of the current packet
    beat_t b2b_beat;     // beat 0 of the next packet, with no gap between packets
    beat_t resume_beat;  // beat 0 of the next packet, at the end of a gap

    // Builds the full output word set for beat b of a packet whose first
    // word is first. The last-beat index is (len-1)/64. The final beat
    // keeps ((len-1) mod 64) + 1 bytes, so a multiple of 64 gives all ones.
    function automatic beat_t make_beat(input logic [15:0] first,
                                        input logic [7:0]  b,
                                        input logic [15:0] len);
        beat_t       r;
        logic [15:0] len_m1;
        logic [15:0] base;
        logic [6:0]  rem;
        len_m1 = len - 16'd1;
        base   = first + {3'b000, b, 5'b00000};
        for (int i = 0; i < 32; i++) begin
            r.data[16*i +: 16] = base + 16'(i);
        end
        r.last = ({2'b00, b} == len_m1[15:6]);
        rem    = {1'b0, len_m1[5:0]} + 7'd1;
        r.keep = r.last ? (~64'd0 >> (7'd64 - rem)) : ~64'd0;
        return r;
    endfunction

    // NOTE: every output of this block is written unconditionally, so no
    // latch can be inferred.
    always_comb begin
        start_beat  = make_beat(initial_value, 8'd0, packet_len);
        next_beat   = make_beat(pkt_first, beat + 8'd1, len_q);
        b2b_beat    = make_beat(pkt_first + 16'd1, 8'd0, len_q);
        resume_beat = make_beat(pkt_first, 8'd0, len_q);
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from values sampled at the same clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the reset is synchronous. It is sampled only on the clock
            // edge, so it has priority over a start in the same cycle.
            state             <= IDLE;
            busy              <= 1'b0;
            axis_out_tvalid   <= 1'b0;
            axis_out_tlast    <= 1'b0;
            axis_out_tdata    <= '0;
            axis_out_tkeep    <= '0;
            len_q             <= '0;
            idle_q            <= '0;
            pkt_first         <= '0;
            gap_cnt           <= '0;
            packets_remaining <= '0;
            beat              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && packet_count != 32'd0 && packet_len != 16'd0) begin
                        len_q             <= packet_len;
                        idle_q            <= idle_cycles;
                        packets_remaining <= packet_count;
                        pkt_first         <= initial_value;
                        beat              <= 8'd0;
                        {axis_out_tdata, axis_out_tkeep, axis_out_tlast} <= start_beat;
                        axis_out_tvalid   <= 1'b1;
                        busy              <= 1'b1;
                        state             <= SEND;
                    end
                end

                SEND: begin
                    if (axis_out_tvalid && axis_out_tready) begin
                        if (axis_out_tlast) begin
                            packets_remaining <= packets_remaining - 32'd1;
                            pkt_first         <= pkt_first + 16'd1;
                            beat              <= 8'd0;
                            if (packets_remaining == 32'd1) begin
                                state           <= IDLE;
                                busy            <= 1'b0;
                                axis_out_tvalid <= 1'b0;
                                axis_out_tlast  <= 1'b0;
                            end else if (idle_q == 16'd0) begin
                                {axis_out_tdata, axis_out_tkeep, axis_out_tlast} <= b2b_beat;
                            end else begin
                                state           <= GAP;
                                gap_cnt         <= idle_q;
                                axis_out_tvalid <= 1'b0;
                                axis_out_tlast  <= 1'b0;
                            end
                        end else begin
                            beat <= beat + 8'd1;
                            {axis_out_tdata, axis_out_tkeep, axis_out_tlast} <= next_beat;
                        end
                    end
                end

                GAP: begin
                    // The gap counter loads with idle_cycles. Leaving at a
                    // count of 1 gives exactly idle_cycles low cycles.
                    if (gap_cnt == 16'd1) begin
                        state           <= SEND;
                        {axis_out_tdata, axis_out_tkeep, axis_out_tlast} <= resume_beat;
                        axis_out_tvalid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_gen.sv
// ---------------------------------------------------------------------------
// tb_packet_gen
//
// Self-checking bench for packet_gen. Each run pushes its expected beats
// into a scoreboard queue. A negedge monitor pops one entry per handshake
// and compares it. The same monitor checks that outputs stay stable under
// backpressure. Hand-computed spot values are checked against a log of the
// received beats.
// ---------------------------------------------------------------------------
module tb_packet_gen;

    typedef struct packed {
        logic         last;
        logic [63:0]  keep;
        logic [511:0] data;
    } bt_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic [15:0]  packet_len;
    logic [31:0]  packet_count;
    logic [15:0]  idle_cycles;
    logic [15:0]  initial_value;
    logic         start;
    logic         busy;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;

    packet_gen dut (
        .clk             (clk),
        .resetn          (resetn),
        .packet_len      (packet_len),
        .packet_count    (packet_count),
        .idle_cycles     (idle_cycles),
        .initial_value   (initial_value),
        .start           (start),
        .busy            (busy),
        .axis_out_tdata  (tdata),
        .axis_out_tkeep  (tkeep),
        .axis_out_tlast  (tlast),
        .axis_out_tvalid (tvalid),
        .axis_out_tready (tready)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   gap_low = 0;
    int   last_hs_cyc = 0;
    bit   rand_ready = 0;
    bit   stall_pending = 0;
    bt_t  stall_beat;
    bt_t  exp_q[$];
    bt_t  log_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) tready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] lane(input bt_t b, input int i);
        return b.data[16*i +: 16];
    endfunction

    // Reference model: lane i of beat b of packet p = init + p + 32*b + i.
    task automatic push_run(input int len, input int count, input logic [15:0] init);
        int beats;
        int rem;
        bt_t e;
        beats = (len + 63) / 64;
        rem   = len - 64 * (beats - 1);
        for (int p = 0; p < count; p++) begin
            for (int b = 0; b < beats; b++) begin
                for (int i = 0; i < 32; i++)
                    e.data[16*i +: 16] = 16'(int'(init) + p + 32 * b + i);
                e.last = (b == beats - 1);
                if (e.last && rem != 64) e.keep = (64'd1 << rem) - 64'd1;
                else                     e.keep = {64{1'b1}};
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: compares handshaken beats, checks that outputs hold during a
    // stall and counts tvalid-low cycles while busy.
    always @(negedge clk) begin
        bt_t cur;
        bt_t e;
        cur = '{last: tlast, keep: tkeep, data: tdata};
        if (stall_pending) begin
            check("stall_valid_hold", tvalid, 1'b1);
            check("stall_beat_hold", cur, stall_beat);
        end
        stall_pending = tvalid && !tready;
        stall_beat    = cur;
        if (busy && !tvalid) gap_low++;
        if (tvalid && tready) begin
            hs_count++;
            last_hs_cyc = cyc;
            log_q.push_back(cur);
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", cur.data, e.data);
                check("beat_keep", cur.keep, e.keep);
                check("beat_last", cur.last, e.last);
            end
        end
    end

    task automatic start_run(input logic [15:0] len, input logic [31:0] count,
                             input logic [15:0] idle, input logic [15:0] init);
        @(posedge clk); #1;
        packet_len = len; packet_count = count; idle_cycles = idle; initial_value = init;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_tvalid", tvalid, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            check("run_timeout", busy, 1'b0);
        end else begin
            check("busy_fall_latency", 32'(cyc - last_hs_cyc), 32'd1);
            check("end_tvalid_low", tvalid, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   busy,   1'b0);
        check({tag, "_tvalid"}, tvalid, 1'b0);
        check({tag, "_tlast"},  tlast,  1'b0);
        check({tag, "_tdata"},  tdata,  512'd0);
        check({tag, "_tkeep"},  tkeep,  64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, g0, l0, n;
        resetn = 1'b0; start = 1'b0; tready = 1'b1;
        packet_len = '0; packet_count = '0; idle_cycles = '0; initial_value = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_reset");

        // Basic run with an ignored start pulse in the middle.
        h0 = hs_count; g0 = gap_low; l0 = log_q.size();
        push_run(256, 2, 16'h0000);
        start_run(16'd256, 32'd2, 16'd1, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        packet_len = 16'd64; packet_count = 32'd5; idle_cycles = 16'd0; initial_value = 16'hAAAA;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200);
        check("basic_handshakes", 32'(hs_count - h0), 32'd8);
        check("basic_gap_cycles", 32'(gap_low - g0), 32'd1);
        check("basic_p0b0_lane0", lane(log_q[l0], 0), 16'h0000);
        check("basic_p0b0_lane31", lane(log_q[l0], 31), 16'h001F);
        check("basic_p1b0_lane0", lane(log_q[l0 + 4], 0), 16'h0001);
        check("basic_tlast_b3", log_q[l0 + 3].last, 1'b1);
        check("basic_tlast_b2", log_q[l0 + 2].last, 1'b0);
        check("basic_tlast_b7", log_q[l0 + 7].last, 1'b1);
        check("basic_keep_b7", log_q[l0 + 7].keep, {64{1'b1}});

        // A start with count = 0 is ignored.
        packet_len = 16'd64; packet_count = 32'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_count_busy", busy, 1'b0);
        check("zero_count_tvalid", tvalid, 1'b0);
        @(posedge clk); #1;
        check("zero_count_busy_later", busy, 1'b0);

        // Partial last beat.
        h0 = hs_count; l0 = log_q.size();
        push_run(100, 1, 16'h0100);
        start_run(16'd100, 32'd1, 16'd3, 16'h0100);
        wait_idle(100);
        check("partial_handshakes", 32'(hs_count - h0), 32'd2);
        check("partial_keep_b1", log_q[l0 + 1].keep, 64'h0000000FFFFFFFFF);
        check("partial_lane0_b1", lane(log_q[l0 + 1], 0), 16'h0120);
        check("partial_last_b1", log_q[l0 + 1].last, 1'b1);

        // Wrap-around of the 16-bit data, with a 2-cycle gap.
        h0 = hs_count; g0 = gap_low; l0 = log_q.size();
        push_run(64, 2, 16'hFFF0);
        start_run(16'd64, 32'd2, 16'd2, 16'hFFF0);
        wait_idle(100);
        check("wrap_handshakes", 32'(hs_count - h0), 32'd2);
        check("wrap_gap_cycles", 32'(gap_low - g0), 32'd2);
        check("wrap_lane15", lane(log_q[l0], 15), 16'hFFFF);
        check("wrap_lane16", lane(log_q[l0], 16), 16'h0000);
        check("wrap_lane31", lane(log_q[l0], 31), 16'h000F);
        check("wrap_p1_lane0", lane(log_q[l0 + 1], 0), 16'hFFF1);

        // Maximum length, back-to-back packets, random backpressure.
        h0 = hs_count; g0 = gap_low;
        push_run(9600, 3, 16'h0500);
        rand_ready = 1;
        start_run(16'd9600, 32'd3, 16'd0, 16'h0500);
        wait_idle(20000);
        rand_ready = 0;
        tready = 1'b1;
        check("bp_handshakes", 32'(hs_count - h0), 32'd450);
        check("bp_gap_cycles", 32'(gap_low - g0), 32'd0);

        // Reset during beat 2 of packet 0, followed by a clean restart.
        h0 = hs_count;
        @(posedge clk); #1;
        push_run(256, 1, 16'h1234);
        start_run(16'd256, 32'd1, 16'd0, 16'h1234);
        n = 0;
        while (hs_count < h0 + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reset_reach_beat2", 32'(hs_count - h0), 32'd2);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        resetn = 1'b1;
        l0 = log_q.size();
        push_run(256, 1, 16'h2000);
        start_run(16'd256, 32'd1, 16'd0, 16'h2000);
        wait_idle(100);
        check("restart_lane0", lane(log_q[l0], 0), 16'h2000);
        check("restart_handshakes", 32'(log_q.size() - l0), 32'd4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
